// File: rtl/newram_pkg.sv
// Shared definitions for the double-buffered LED frame RAM: FSM encodings and
// default geometry.
package newram_pkg;

  localparam int DEF_DATA_W = 2;
  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DEPTH  = 2048;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    CLEAR   = 2'd2
  } state_t;

endpackage

// File: rtl/newram_bank.sv
// One frame bank: simple dual-port inferred RAM with a registered read port,
// shaped so it maps onto iCE40 block RAM.
module newram_bank #(
  parameter int DATA_W = 2,
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 2048
) (
  input  logic              clock,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic              rdEn,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [DATA_W-1:0] rdData
);

  logic [DATA_W-1:0] mem [DEPTH];

  // No reset on the output register so the read stage stays inside the BRAM.
  always_ff @(posedge clock) begin
    if (wrEn) mem[wrAddr] <= wrData;
    if (rdEn) rdData <= mem[rdAddr];
  end

endmodule

// File: rtl/newram_pingpong.sv
// Double-buffered frame RAM: producer fills the back bank, display reads the
// front bank, banks swap only on FrameEnd. Optional post-swap clear: NEWRAM_PINGPONG_CLEAR_EN.
module newram_pingpong
  import newram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              Clock,
  input  logic              ResetN,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [DATA_W-1:0] WrData,
  input  logic              RdEn,
  input  logic [ADDR_W-1:0] RdAddr,
  output logic [DATA_W-1:0] RdData,
  input  logic              FrameEnd,
  input  logic              SwapReq,
  output logic              SwapPending,
  output logic              SwapAck,
  output logic              FrontBank,
  output logic              Busy
);

  localparam logic [ADDR_W:0] depthX = (ADDR_W + 1)'(DEPTH);

  state_t            state;
  logic              swapNow;
  logic              wrInRange;
  logic              rdInRange;
  logic              wrAny;
  logic [ADDR_W-1:0] bankWrAddr;
  logic [DATA_W-1:0] bankWrData;
  logic [1:0]        bankWrEn;
  logic [1:0]        bankRdEn;
  logic [DATA_W-1:0] bankRdData [2];
  logic              rdSel;
  logic              rdZero;

  always_comb begin
    wrInRange = ({1'b0, WrAddr} < depthX);
    rdInRange = ({1'b0, RdAddr} < depthX);
    swapNow   = FrameEnd & (((state == IDLE) & SwapReq) | (state == PENDING));
  end

`ifdef NEWRAM_PINGPONG_CLEAR_EN
  localparam logic [ADDR_W-1:0] lastAddr = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] clrAddr;
  logic              clearing;

  // While clearing, the back-bank write port belongs to the clear sequencer.
  always_comb begin
    clearing   = (state == CLEAR);
    bankWrAddr = clearing ? clrAddr : WrAddr;
    bankWrData = clearing ? '0 : WrData;
    wrAny      = clearing | (WrEn & wrInRange);
  end
`else
  always_comb begin
    bankWrAddr = WrAddr;
    bankWrData = WrData;
    wrAny      = WrEn & wrInRange;
  end

  assign Busy = 1'b0;
`endif

  // Writes go to the back bank, reads to the front bank, so the ports never collide.
  always_comb begin
    bankWrEn = {wrAny & ~FrontBank, wrAny & FrontBank};
    bankRdEn = {RdEn & rdInRange & FrontBank, RdEn & rdInRange & ~FrontBank};
  end

  for (genvar b = 0; b < 2; b++) begin : gBank
    newram_bank #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .DEPTH (DEPTH)
    ) uBank (
      .clock (Clock),
      .wrEn  (bankWrEn[b]),
      .wrAddr(bankWrAddr),
      .wrData(bankWrData),
      .rdEn  (bankRdEn[b]),
      .rdAddr(RdAddr),
      .rdData(bankRdData[b])
    );
  end

  // The bank output registers carry the data; these flags remember which bank was
  // read and whether the address was out of range, giving reset-to-zero RdData.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      rdSel  <= 1'b0;
      rdZero <= 1'b1;
    end else if (RdEn) begin
      rdSel  <= FrontBank;
      rdZero <= ~rdInRange;
    end
  end

  assign RdData = rdZero ? '0 : bankRdData[rdSel];

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state       <= IDLE;
      FrontBank   <= 1'b0;
      SwapPending <= 1'b0;
      SwapAck     <= 1'b0;
`ifdef NEWRAM_PINGPONG_CLEAR_EN
      Busy        <= 1'b0;
      clrAddr     <= '0;
`endif
    end else begin
      SwapAck <= 1'b0;
      if (swapNow) begin
        FrontBank   <= ~FrontBank;
        SwapAck     <= 1'b1;
        SwapPending <= 1'b0;
`ifdef NEWRAM_PINGPONG_CLEAR_EN
        state       <= CLEAR;
        Busy        <= 1'b1;
        clrAddr     <= '0;
`else
        state       <= IDLE;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (SwapReq) begin
              state       <= PENDING;
              SwapPending <= 1'b1;
            end
          end
          PENDING: ;
`ifdef NEWRAM_PINGPONG_CLEAR_EN
          CLEAR: begin
            if (clrAddr == lastAddr) begin
              state <= IDLE;
              Busy  <= 1'b0;
            end else begin
              clrAddr <= clrAddr + ADDR_W'(1);
            end
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/newram_pingpong.md
Name: newram_pingpong

Overview:
- Parametrised, double-buffered frame RAM for the LED panel path; successor to the fixed 2-bit x 2048 RAM wrapper.
- Two banks, each DEPTH x DATA_W. The producer writes the back bank while the scan/display side reads the front bank.
- A swap handshake exchanges the banks only at a display frame boundary, so the panel never shows a torn frame.
- Single clock domain; memory is inferred so it maps to iCE40 block RAM.

Parameters:
- DATA_W, 2, bits per stored word.
- ADDR_W, 11, address width of each bank.
- DEPTH, 2048, words per bank; must satisfy DEPTH <= 2**ADDR_W.

Ports:
- Clock  in  1  system clock; all logic is on the rising edge.
- ResetN  in  1  asynchronous, active-low reset.
- WrEn  in  1  write strobe into the back bank.
- WrAddr  in  ADDR_W  write address.
- WrData  in  DATA_W  write data.
- RdEn  in  1  read strobe from the front bank.
- RdAddr  in  ADDR_W  read address.
- RdData  out  DATA_W  registered read data.
- FrameEnd  in  1  one-cycle pulse from the scan logic at the end of a frame.
- SwapReq  in  1  one-cycle pulse from the producer: back bank is complete.
- SwapPending  out  1  a swap is accepted and waiting for FrameEnd.
- SwapAck  out  1  one-cycle pulse: the swap has happened.
- FrontBank  out  1  index of the bank currently being displayed.
- Busy  out  1  post-swap clear in progress; tied to 0 without the optional feature.

Behaviour:
- Reset (asynchronous on ResetN low, in any state):
  - RdData=0, FrontBank=0, SwapPending=0, SwapAck=0, Busy=0, FSM=IDLE.
  - RAM contents are not reset.
  - Reset during PENDING or CLEAR aborts the operation. No SwapAck is issued, and a partially cleared bank stays partially cleared.
- Write path:
  - Rising edge with WrEn=1 and WrAddr<DEPTH writes WrData into bank ~FrontBank, using the FrontBank value from before the edge.
  - WrAddr>=DEPTH: write ignored.
  - A write on the swap edge lands in the bank that becomes front.
- Read path:
  - 1-cycle latency. At an edge with RdEn=1, RdData takes front bank[RdAddr], using FrontBank from before the edge.
  - RdEn=0 holds RdData.
  - RdAddr>=DEPTH returns 0.
  - No read/write collision is possible, because the two ports always address different banks.
- FSM states: IDLE, PENDING, CLEAR.
  - IDLE, SwapReq=1, FrameEnd=0: go to PENDING; SwapPending=1 from the next cycle.
  - IDLE, SwapReq=1 and FrameEnd=1 in the same cycle: swap at that edge.
  - PENDING, FrameEnd=1: swap at that edge; SwapPending=0.
  - PENDING, SwapReq=1: ignored; the request is already pending.
  - A swap means: FrontBank toggles, and SwapAck=1 for exactly the following cycle.
  - Next state after a swap is IDLE, or CLEAR when the optional feature is compiled in.
  - FrameEnd in IDLE with no request: no effect.
  - SwapReq is accepted only in IDLE. Requests arriving in CLEAR are dropped; the producer must wait for Busy=0.

Optional Feature:
- Macro: NEWRAM_PINGPONG_CLEAR_EN.
- When defined:
  - After each swap the FSM enters CLEAR with Busy=1.
  - It writes 0 to the new back bank at addresses 0..DEPTH-1, one word per cycle, over exactly DEPTH cycles.
  - Busy falls in the cycle after the write to address DEPTH-1.
  - User writes during CLEAR are ignored; reads are unaffected.
- When undefined:
  - There is no CLEAR state and Busy is tied to 0.
  - The back bank keeps the contents of the frame before last.

Decomposition:
- Shared package/include newram_pkg holds:
  - FSM state encodings (IDLE=2'd0, PENDING=2'd1, CLEAR=2'd2).
  - Default DATA_W/ADDR_W/DEPTH constants.
- One sub-module, newram_bank:
  - Simple dual-port inferred RAM (write port, read port with 1-cycle registered output).
  - Instantiated twice.
  - Top level muxes write-enable and read data by FrontBank.

Test Plan:
- Reset and first read: hold ResetN=0, then release; write 0x3 to addr 5, then read addr 5 -> RdData=0 (front bank 0 is unwritten/cleared), FrontBank=0, SwapPending=0.
- Basic swap:
  - Write bank with addr k = k%4 for k=0..2047.
  - SwapReq, then FrameEnd 10 cycles later -> SwapPending high for those 10 cycles, SwapAck single pulse, FrontBank=1.
  - Reading addr 7 -> 0x3.
- Simultaneous events:
  - SwapReq and FrameEnd in the same cycle -> swap on that edge, SwapPending never asserts.
  - Duplicate SwapReq while PENDING -> exactly one SwapAck.
- Swap-edge ordering:
  - Read addr 9 on the swap edge -> old front data.
  - Write 0x2 to addr 9 on the same edge -> visible on a read of addr 9 in the following cycle.
- Out-of-range access (DEPTH=1000, ADDR_W=10): write addr 1000 -> ignored; read addr 1000 -> RdData=0.
- NEWRAM_PINGPONG_CLEAR_EN:
  - After a swap, Busy is high for exactly DEPTH cycles and the new back bank reads all 0 after the next swap.
  - Assert ResetN low mid-clear -> Busy=0 immediately, FSM=IDLE.
